// File: rtl/bag_piece_generator.sv
// bag_piece_generator
//   Piece source for the per-player tetromino control logic. A 16-bit Galois
//   LFSR (perturbed by player moves) selects a start point for a 7-bag draw.
//   Draws go into a short shift-register queue. The queue head is the current
//   piece, and the entries behind it form the preview.
//
// Ports
//   Clk          system clock
//   Reset        synchronous, active-high
//   new_block    consume the head piece (ignored while the queue is empty)
//   new_move     move code from the control logic, 0 = none
//   block_idx    head piece index, 3'd7 when empty
//   preview_idx  entries 1..PREVIEW_DEPTH, entry 1 in bits [2:0], 3'd7 when empty
//   ready        high once the queue has filled after reset
module bag_piece_generator #(
  parameter int unsigned PREVIEW_DEPTH = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         new_block,
  input  logic [2:0]                   new_move,
  output logic [2:0]                   block_idx,
  output logic [3*PREVIEW_DEPTH-1:0]   preview_idx,
  output logic                         ready
);

  localparam int unsigned QD        = PREVIEW_DEPTH + 1;
  localparam int unsigned CW        = $clog2(QD + 1);
  localparam logic [2:0]  EMPTY     = 3'd7;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic {INIT, RUN} state_t;

  state_t        state, state_next;
  logic [15:0]   lfsr, lfsr_shift, lfsr_mix, lfsr_next;
  logic [6:0]    used, used_set, used_next;
  logic [2:0]    q      [QD];
  logic [2:0]    q_next [QD];
  logic [CW-1:0] count, count_next, base;
  logic          pop, fill;
  logic [2:0]    start, draw;
  logic [3:0]    cand;
  logic          found;

  // LFSR: shift, mix in the move code, and never allow the all-zero lock-up state.
  always_comb begin
    lfsr_shift = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
    lfsr_mix   = lfsr_shift ^ {13'b0, new_move};
    lfsr_next  = (lfsr_mix == 16'h0000) ? LFSR_SEED : lfsr_mix;
  end

  // Bag draw: scan from the start point, wrapping mod 7, and take the first
  // piece not yet used. At least one piece is always free because a full mask
  // is cleared on the same edge that fills it.
  assign start = (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];

  // NOTE: every variable written in a combinational block gets a value before
  // any conditional logic, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    draw  = 3'd0;
    found = 1'b0;
    cand  = 4'd0;
    for (int k = 0; k < 7; k++) begin
      cand = {1'b0, start} + 4'(k);
      if (cand >= 4'd7) cand = cand - 4'd7;
      if (!found && !used[cand[2:0]]) begin
        draw  = cand[2:0];
        found = 1'b1;
      end
    end
  end

  // Queue control. A pop on an empty queue is dropped, so holding new_block
  // high at startup does not discard anything.
  assign pop        = new_block && (count != '0);
  assign base       = count - CW'(pop);
  assign fill       = (base < CW'(QD));
  assign count_next = base + CW'(fill);
  assign used_set   = used | (7'b1 << draw);
  assign used_next  = fill ? ((used_set == 7'h7F) ? 7'h00 : used_set) : used;

  always_comb begin
    for (int i = 0; i < QD; i++) q_next[i] = q[i];
    if (pop) begin
      for (int i = 0; i < QD - 1; i++) q_next[i] = q[i + 1];
      q_next[QD-1] = EMPTY;
    end
    // The draw lands in the first empty slot after any shift on this edge.
    for (int i = 0; i < QD; i++) begin
      if (fill && (base == CW'(i))) q_next[i] = draw;
    end
  end

  always_comb begin
    state_next = state;
    if ((state == INIT) && (count_next == CW'(QD))) state_next = RUN;
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values from before this edge, whatever the statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lfsr  <= LFSR_SEED;
      used  <= 7'h00;
      count <= '0;
      state <= INIT;
      // NOTE: the queue entries are reset explicitly because an empty slot must
      // read as 3'd7 on the outputs, not as whatever it held before reset.
      for (int i = 0; i < QD; i++) q[i] <= EMPTY;
    end else begin
      lfsr  <= lfsr_next;
      used  <= used_next;
      count <= count_next;
      state <= state_next;
      for (int i = 0; i < QD; i++) q[i] <= q_next[i];
    end
  end

  // All outputs come straight from registers.
  assign block_idx = q[0];
  assign ready     = (state == RUN);
  always_comb begin
    for (int i = 0; i < PREVIEW_DEPTH; i++) preview_idx[3*i +: 3] = q[i + 1];
  end

endmodule

// File: tb/tb_bag_piece_generator.sv
// Directed bench for bag_piece_generator. The expected values were worked out
// by hand from the LFSR sequence seeded with 16'hACE1:
//   ACE1 E270 7138 389C 1C4E 0E27 B313 ED89 ...
//   start points 1 0 0 4 6 7->0 3 1, giving draws 1 0 2 4 6 3 5 | 1 ...
// A second instance, seeded with 16'h0002, exercises the lock-up guard.
module tb_bag_piece_generator;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       new_block;
  logic [2:0] new_move;
  logic [2:0] block_idx;
  logic [8:0] preview_idx;
  logic       ready;

  logic [2:0] new_move2;
  logic [2:0] block_idx2;
  logic [8:0] preview_idx2;
  logic       ready2;

  int vectors   = 0;
  int miscompares = 0;

  always #10 Clk = ~Clk;

  bag_piece_generator dut (
    .Clk(Clk), .Reset(Reset), .new_block(new_block), .new_move(new_move),
    .block_idx(block_idx), .preview_idx(preview_idx), .ready(ready)
  );

  bag_piece_generator #(.LFSR_SEED(16'h0002)) dut2 (
    .Clk(Clk), .Reset(Reset), .new_block(1'b0), .new_move(new_move2),
    .block_idx(block_idx2), .preview_idx(preview_idx2), .ready(ready2)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the edge and outputs are sampled there.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; new_block = 1'b0; new_move = 3'd0; new_move2 = 3'd0;
    #1;

    // Reset held three cycles.
    tick(); tick(); tick();
    check("rst_block",   16'(block_idx),   16'h7);
    check("rst_preview", 16'(preview_idx), 16'h1FF);
    check("rst_ready",   16'(ready),       16'h0);

    // Fill, one draw per edge. dut2 sees move 1 on its first edge, which
    // would drive its LFSR to zero without the reseed.
    Reset = 1'b0; new_move2 = 3'd1;
    tick();                                  // edge 1
    new_move2 = 3'd0;
    check("e1_block",    16'(block_idx),   16'h1);
    check("e1_preview",  16'(preview_idx), 16'h1FF);
    check("e1_ready",    16'(ready),       16'h0);
    check("lockup_lfsr", dut2.lfsr,        16'h0002);
    tick();                                  // edge 2
    check("e2_preview",  16'(preview_idx), 16'h1F8);
    check("e2_ready",    16'(ready),       16'h0);
    check("lockup_draw", 16'(preview_idx2[2:0]), 16'h3);
    tick();                                  // edge 3
    check("e3_preview",  16'(preview_idx), 16'h1D0);
    check("e3_ready",    16'(ready),       16'h0);
    tick();                                  // edge 4
    check("e4_block",    16'(block_idx),   16'h1);
    check("e4_preview",  16'(preview_idx), 16'h110);
    check("e4_ready",    16'(ready),       16'h1);
    check("e4_used",     16'(dut.used),    16'h17);

    // Back-to-back pops, with refill on the same edge.
    new_block = 1'b1;
    tick();                                  // edge 5, draws 6
    check("p1_block",    16'(block_idx),   16'h0);
    check("p1_preview",  16'(preview_idx), 16'h1A2);
    tick();                                  // edge 6, start 7 maps to 0, draws 3
    check("p2_block",    16'(block_idx),   16'h2);
    check("p2_preview",  16'(preview_idx), 16'h0F4);
    tick();                                  // edge 7, draws 5 and completes the bag
    check("p3_block",    16'(block_idx),   16'h4);
    check("p3_preview",  16'(preview_idx), 16'h15E);
    check("p3_used",     16'(dut.used),    16'h00);
    tick();                                  // edge 8, new bag, draws 1
    check("p4_block",    16'(block_idx),   16'h6);
    check("p4_preview",  16'(preview_idx), 16'h06B);
    check("p4_used",     16'(dut.used),    16'h02);
    check("p4_ready",    16'(ready),       16'h1);

    // Reset on the same edge as a pop: reset wins.
    Reset = 1'b1;
    tick();
    new_block = 1'b0;
    check("mid_block",   16'(block_idx),   16'h7);
    check("mid_preview", 16'(preview_idx), 16'h1FF);
    check("mid_ready",   16'(ready),       16'h0);
    Reset = 1'b0;
    tick();
    check("mid_e1_block", 16'(block_idx), 16'h1);
    tick(); tick(); tick();
    check("mid_e4_preview", 16'(preview_idx), 16'h110);
    check("mid_e4_ready",   16'(ready),       16'h1);

    // new_block held high from reset release: the queue never holds more than one entry.
    Reset = 1'b1;
    tick();
    Reset = 1'b0; new_block = 1'b1;
    tick();
    check("hold_e1_block", 16'(block_idx), 16'h1);
    tick();
    check("hold_e2_block", 16'(block_idx), 16'h0);
    tick();
    check("hold_e3_block", 16'(block_idx), 16'h2);
    tick();
    check("hold_e4_block", 16'(block_idx), 16'h4);
    check("hold_e4_ready", 16'(ready),     16'h0);
    check("hold_e4_used",  16'(dut.used),  16'h17);
    new_block = 1'b0;
    tick();                                  // edge 5, draws 6
    check("hold_e5_preview", 16'(preview_idx), 16'h1FE);
    tick(); tick();                          // edges 6, 7, draws 3 and 5
    check("hold_e7_block",   16'(block_idx),   16'h4);
    check("hold_e7_preview", 16'(preview_idx), 16'h15E);
    check("hold_e7_ready",   16'(ready),       16'h1);

    // One move pulse on edge 1. The first draw is unchanged, and the second
    // diverges (LFSR E271, start 1, so the draw is 2 instead of 0).
    Reset = 1'b1;
    tick();
    Reset = 1'b0; new_move = 3'd1;
    tick();
    new_move = 3'd0;
    check("mv_e1_block", 16'(block_idx), 16'h1);
    tick();
    check("mv_e2_preview", 16'(preview_idx[2:0]), 16'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
